// File: rtl/snow_pkg.sv
// Shared constants, flake position table and FSM state type
// for the snowflake collection scanner.
package snow_pkg;

  localparam int N_SNOW = 15;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int HIT_W  = 16;
  localparam int HIT_H  = 16;
  localparam int IDX_W  = 4;

  typedef enum logic {
    WAIT,
    SCAN
  } state_e;

  localparam logic [X_W-1:0] SNOW_X [N_SNOW] = '{
    10'd40,  10'd120, 10'd200, 10'd280, 10'd360,
    10'd440, 10'd520, 10'd600, 10'd5,   10'd160,
    10'd240, 10'd320, 10'd400, 10'd480, 10'd560
  };

  localparam logic [Y_W-1:0] SNOW_Y [N_SNOW] = '{
    9'd60,  9'd200, 9'd100, 9'd300, 9'd150,
    9'd400, 9'd250, 9'd350, 9'd440, 9'd30,
    9'd380, 9'd120, 9'd260, 9'd220, 9'd420
  };

endpackage

// File: rtl/snow_hit_cmp.sv
// Combinational hitbox overlap test: strict absolute-distance
// window on both axes, computed one bit wider so nothing wraps.
module snow_hit_cmp
  import snow_pkg::*;
(
  input  logic [X_W-1:0] px_i,
  input  logic [Y_W-1:0] py_i,
  input  logic [X_W-1:0] sx_i,
  input  logic [Y_W-1:0] sy_i,
  output logic           hit_o
);

  logic [X_W:0] dx;
  logic [Y_W:0] dy;

  always_comb begin
    dx = (px_i >= sx_i) ? ({1'b0, px_i} - {1'b0, sx_i})
                        : ({1'b0, sx_i} - {1'b0, px_i});
    dy = (py_i >= sy_i) ? ({1'b0, py_i} - {1'b0, sy_i})
                        : ({1'b0, sy_i} - {1'b0, py_i});
    hit_o = (dx < (X_W+1)'(HIT_W)) && (dy < (Y_W+1)'(HIT_H));
  end

endmodule

// File: rtl/snowflake_collect.sv
// Per-frame snowflake scanner with sticky collected mask.
// Optional GET_PULSE_EN adds get_pulse/get_idx collect events.
module snowflake_collect
  import snow_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              game_start,
  input  logic              game_en,
  input  logic [X_W-1:0]    player_x,
  input  logic [Y_W-1:0]    player_y,
  output logic [N_SNOW-1:0] snowf_get,
  output logic [N_SNOW-1:0] snowf_vis,
  output logic              all_got,
  output logic              busy
`ifdef GET_PULSE_EN
  ,
  output logic              get_pulse,
  output logic [IDX_W-1:0]  get_idx
`endif
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [X_W-1:0]      px_q, px_d;
  logic [Y_W-1:0]      py_q, py_d;
  logic [N_SNOW-1:0]   get_q, get_d;
  logic                all_q, all_d;
  logic                hit;
`ifdef GET_PULSE_EN
  logic                pulse_q, pulse_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
`endif

  snow_hit_cmp u_cmp (
    .px_i  (px_q),
    .py_i  (py_q),
    .sx_i  (SNOW_X[idx_q]),
    .sy_i  (SNOW_Y[idx_q]),
    .hit_o (hit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    get_d   = get_q;
    all_d   = &get_q;
`ifdef GET_PULSE_EN
    pulse_d = 1'b0;
    gidx_d  = gidx_q;
`endif
    if (game_start) begin
      state_d = WAIT;
      idx_d   = '0;
      get_d   = '0;
      all_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (frame_tick && game_en) begin
            px_d    = player_x;
            py_d    = player_y;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          // only a fresh collect raises the pulse
          if (hit && !get_q[idx_q]) begin
            get_d[idx_q] = 1'b1;
`ifdef GET_PULSE_EN
            pulse_d = 1'b1;
            gidx_d  = idx_q;
`endif
          end
          if (idx_q == IDX_W'(N_SNOW-1)) begin
            idx_d   = '0;
            state_d = WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      idx_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      get_q   <= '0;
      all_q   <= 1'b0;
`ifdef GET_PULSE_EN
      pulse_q <= 1'b0;
      gidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      get_q   <= get_d;
      all_q   <= all_d;
`ifdef GET_PULSE_EN
      pulse_q <= pulse_d;
      gidx_q  <= gidx_d;
`endif
    end
  end

  assign snowf_get = get_q;
  assign snowf_vis = ~get_q;
  assign all_got   = all_q;
  assign busy      = (state_q == SCAN);
`ifdef GET_PULSE_EN
  assign get_pulse = pulse_q;
  assign get_idx   = gidx_q;
`endif

endmodule

// File: tb/tb_snowflake_collect.sv
// Directed-vector bench for snowflake_collect.
module tb_snowflake_collect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        game_start;
  logic        game_en;
  logic [9:0]  player_x;
  logic [8:0]  player_y;
  logic [14:0] snowf_get;
  logic [14:0] snowf_vis;
  logic        all_got;
  logic        busy;
`ifdef GET_PULSE_EN
  logic        get_pulse;
  logic [3:0]  get_idx;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  int tx [15] = '{40, 120, 200, 280, 360, 440, 520, 600,
                  5, 160, 240, 320, 400, 480, 560};
  int ty [15] = '{60, 200, 100, 300, 150, 400, 250, 350,
                  440, 30, 380, 120, 260, 220, 420};

  always #5 clk = ~clk;

  snowflake_collect dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .game_start (game_start),
    .game_en    (game_en),
    .player_x   (player_x),
    .player_y   (player_y),
    .snowf_get  (snowf_get),
    .snowf_vis  (snowf_vis),
    .all_got    (all_got),
    .busy       (busy)
`ifdef GET_PULSE_EN
    ,
    .get_pulse  (get_pulse),
    .get_idx    (get_idx)
`endif
  );

`ifdef GET_PULSE_EN
  always @(posedge clk) if (get_pulse) pulses <= pulses + 1;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      cyc();
    end
  endtask

  task automatic run_scan(input int x, input int y, output int cnt);
    player_x   = 10'(x);
    player_y   = 9'(y);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    wait_idle(cnt);
  endtask

  int cnt;
  int p0;

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    game_start = 1'b0;
    game_en    = 1'b1;
    player_x   = '0;
    player_y   = '0;
    cyc(); cyc(); cyc();
    chk("rst_get", 32'(snowf_get), 32'h0);
    chk("rst_vis", 32'(snowf_vis), 32'h7fff);
    chk("rst_all", 32'(all_got), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    cyc();

    run_scan(40, 60, cnt);
    chk("t1_busy_len", 32'(cnt), 32'd15);
    cyc();
    chk("t1_get", 32'(snowf_get), 32'h0001);
    chk("t1_vis", 32'(snowf_vis), 32'h7ffe);
    chk("t1_all", 32'(all_got), 32'h0);

    clear();
    run_scan(55, 60, cnt);
    chk("t2_dx15", 32'(snowf_get), 32'h0001);
    clear();
    run_scan(56, 60, cnt);
    chk("t2_dx16", 32'(snowf_get), 32'h0000);
    clear();
    run_scan(40, 75, cnt);
    chk("t2_dy15", 32'(snowf_get), 32'h0001);
    clear();
    run_scan(40, 76, cnt);
    chk("t2_dy16", 32'(snowf_get), 32'h0000);
    run_scan(0, 440, cnt);
    chk("t2_x0_flake5", 32'(snowf_get), 32'h0100);

    game_en    = 1'b0;
    player_x   = 10'd40;
    player_y   = 9'd60;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("t2_en_off_busy", 32'(busy), 32'h0);
    game_en = 1'b1;

    clear();
    player_x   = 10'd40;
    player_y   = 9'd60;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    player_x   = 10'd120;
    player_y   = 9'd200;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    wait_idle(cnt);
    chk("t3_drop_len", 32'(cnt), 32'd13);
    chk("t3_drop_get", 32'(snowf_get), 32'h0001);
    run_scan(120, 200, cnt);
    chk("t3_get", 32'(snowf_get), 32'h0003);

    player_x   = 10'd200;
    player_y   = 9'd100;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc(); cyc(); cyc();
    game_start = 1'b1;
    frame_tick = 1'b1;
    cyc();
    game_start = 1'b0;
    frame_tick = 1'b0;
    chk("t4_get", 32'(snowf_get), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    cyc(); cyc();
    chk("t4_no_scan", 32'(busy), 32'h0);

    player_x   = 10'd600;
    player_y   = 9'd350;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    game_en  = 1'b0;
    player_x = 10'd40;
    player_y = 9'd60;
    wait_idle(cnt);
    chk("t4_en_fall_len", 32'(cnt), 32'd14);
    chk("t4_en_fall_get", 32'(snowf_get), 32'h0080);
    game_en = 1'b1;

    clear();
    p0 = pulses;
    for (int k = 0; k < 15; k++) run_scan(tx[k], ty[k], cnt);
    chk("t5_get", 32'(snowf_get), 32'h7fff);
    chk("t5_all_lag", 32'(all_got), 32'h0);
    cyc();
    chk("t5_all", 32'(all_got), 32'h1);
    chk("t5_vis", 32'(snowf_vis), 32'h0);
`ifdef GET_PULSE_EN
    chk("t5_pulses", 32'(pulses - p0), 32'd15);
    chk("t5_idx", 32'(get_idx), 32'd14);
    run_scan(40, 60, cnt);
    chk("t5_repeat_pulse", 32'(pulses - p0), 32'd15);
    chk("t5_repeat_idx", 32'(get_idx), 32'd14);
`endif

    player_x   = 10'd40;
    player_y   = 9'd60;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (7) cyc();
    chk("t6_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_get", 32'(snowf_get), 32'h0);
    chk("t6_vis", 32'(snowf_vis), 32'h7fff);
    chk("t6_all", 32'(all_got), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_scan(120, 200, cnt);
    chk("t6_len", 32'(cnt), 32'd15);
    chk("t6_get_after", 32'(snowf_get), 32'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
